button_event_decoder: RTL and testbench

Consumes the debounced button level from the button debouncer and classifies each press as a short press, a long press, or a sustained hold with auto-repeat. It emits single-cycle event pulses to the time-setting logic of the clock, so that, for example, a tap advances a digit by one and a hold scrolls it. One instance is used per physical button, downstream of that button's debouncer.

---
 rtl/button_event_decoder_if.sv | 25 ++
 rtl/button_event_decoder.sv | 92 +++++++++
 tb/tb_button_event_decoder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/button_event_decoder_if.sv
// Signal bundle between a debounced button source and the button event decoder.
// The decoder takes the slave side; the producer/consumer of events takes the master side.
interface button_event_decoder_if;
   logic i_Button_State;
   logic o_Short_Press;
   logic o_Long_Press;
   logic o_Repeat;
   logic o_Held;

   modport master (
      output i_Button_State,
      input  o_Short_Press,
      input  o_Long_Press,
      input  o_Repeat,
      input  o_Held
   );

   modport slave (
      input  i_Button_State,
      output o_Short_Press,
      output o_Long_Press,
      output o_Repeat,
      output o_Held
   );
endinterface

// File: rtl/button_event_decoder.sv
// Classifies debounced presses into short press, long press and auto-repeat while held.
// All outputs are registered; events are single-cycle pulses.
module button_event_decoder #(
   parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
   parameter int unsigned REPEAT_CYCLES     = 10_000_000,
   parameter int unsigned COUNTER_WIDTH     = 26
) (
   input logic                  i_Clock,
   input logic                  i_Reset,
   button_event_decoder_if.slave bus
);

   typedef enum logic [1:0] {StLockout, StIdle, StPressed, StHeld} state_t;

   localparam logic [COUNTER_WIDTH-1:0] LongLast   = COUNTER_WIDTH'(LONG_PRESS_CYCLES - 1);
   localparam logic [COUNTER_WIDTH-1:0] RepeatLast = COUNTER_WIDTH'(REPEAT_CYCLES - 1);

   state_t                   state_q;
   logic [COUNTER_WIDTH-1:0] counter_q;
   logic                     short_q;
   logic                     long_q;
   logic                     repeat_q;
   logic                     held_q;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q   <= StLockout;
         counter_q <= '0;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         repeat_q <= 1'b0;
         unique case (state_q)
            // A button held through reset must be released before it can count.
            StLockout: begin
               if (!bus.i_Button_State) begin
                  state_q   <= StIdle;
                  counter_q <= '0;
               end
            end
            StIdle: begin
               if (bus.i_Button_State) begin
                  state_q   <= StPressed;
                  counter_q <= '0;
               end
            end
            StPressed: begin
               if (!bus.i_Button_State) begin
                  short_q   <= 1'b1;
                  state_q   <= StIdle;
                  counter_q <= '0;
               end else if (counter_q == LongLast) begin
                  long_q    <= 1'b1;
                  held_q    <= 1'b1;
                  state_q   <= StHeld;
                  counter_q <= '0;
               end else begin
                  counter_q <= counter_q + 1'b1;
               end
            end
            StHeld: begin
               // Release takes priority over a coincident repeat.
               if (!bus.i_Button_State) begin
                  held_q    <= 1'b0;
                  state_q   <= StIdle;
                  counter_q <= '0;
               end else if (counter_q == RepeatLast) begin
                  repeat_q  <= 1'b1;
                  counter_q <= '0;
               end else begin
                  counter_q <= counter_q + 1'b1;
               end
            end
            default: begin
               state_q   <= StLockout;
               counter_q <= '0;
               held_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_Short_Press = short_q;
   assign bus.o_Long_Press  = long_q;
   assign bus.o_Repeat      = repeat_q;
   assign bus.o_Held        = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: a press-duration model queues expected
// pulses and a negedge monitor compares them against the DUT outputs.
module tb_button_event_decoder;

   localparam int unsigned Long = 8;
   localparam int unsigned Rep  = 4;

   logic i_Clock = 1'b0;
   logic i_Reset = 1'b1;

   button_event_decoder_if bus ();

   button_event_decoder #(
      .LONG_PRESS_CYCLES(Long),
      .REPEAT_CYCLES    (Rep),
      .COUNTER_WIDTH    (4)
   ) dut (
      .i_Clock(i_Clock),
      .i_Reset(i_Reset),
      .bus    (bus.slave)
   );

   always #5 i_Clock = ~i_Clock;

   // kind bits: {short, long, repeat}
   typedef struct {
      int         ev_edge;
      logic [2:0] kind;
   } ev_t;

   ev_t  exp_q[$];
   int   edge_cnt = 0;
   int   n_cmp    = 0;
   int   n_bad    = 0;
   bit   mon_en   = 1'b0;

   // Reference model: press duration measured in sampled edges since the press edge.
   bit   locked   = 1'b1;
   bit   pressing = 1'b0;
   int   dur      = 0;
   bit   exp_held = 1'b0;

   task automatic push_ev(input logic [2:0] kind);
      ev_t e;
      e.ev_edge = edge_cnt;
      e.kind    = kind;
      exp_q.push_back(e);
   endtask

   task automatic model(input bit b, input bit r);
      edge_cnt++;
      if (r) begin
         locked   = 1'b1;
         pressing = 1'b0;
         exp_held = 1'b0;
      end else if (locked) begin
         if (!b) locked = 1'b0;
      end else if (!pressing) begin
         if (b) begin
            pressing = 1'b1;
            dur      = 0;
         end
      end else begin
         dur++;
         if (!b) begin
            if (dur <= int'(Long)) push_ev(3'b100);
            pressing = 1'b0;
            exp_held = 1'b0;
         end else begin
            if (dur == int'(Long)) push_ev(3'b010);
            else if (dur > int'(Long) && (dur - int'(Long)) % int'(Rep) == 0) push_ev(3'b001);
            exp_held = (dur >= int'(Long));
         end
      end
   endtask

   task automatic step(input bit b, input bit r);
      bus.i_Button_State = b;
      i_Reset            = r;
      @(posedge i_Clock);
      model(b, r);
      mon_en = 1'b1;
      #1;
   endtask

   task automatic hold(input bit b, input int cycles);
      for (int i = 0; i < cycles; i++) step(b, 1'b0);
   endtask

   // Monitor: compares every cycle away from the active edge.
   always @(negedge i_Clock) begin
      if (mon_en) begin
         logic [2:0] obs;
         obs = {bus.o_Short_Press, bus.o_Long_Press, bus.o_Repeat};
         n_cmp++;
         if (bus.o_Held !== exp_held) begin
            n_bad++;
            $display("FAIL held edge=%0d got=%b want=%b", edge_cnt, bus.o_Held, exp_held);
         end
         if (obs != 3'b000) begin
            n_cmp++;
            if (exp_q.size() == 0 || exp_q[0].ev_edge != edge_cnt) begin
               n_bad++;
               $display("FAIL unexpected_event edge=%0d got=%b want=none", edge_cnt, obs);
            end else begin
               if (obs !== exp_q[0].kind) begin
                  n_bad++;
                  $display("FAIL event_kind edge=%0d got=%b want=%b", edge_cnt, obs,
                           exp_q[0].kind);
               end
               void'(exp_q.pop_front());
            end
         end else if (exp_q.size() != 0 && exp_q[0].ev_edge <= edge_cnt) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_event edge=%0d got=000 want=%b", edge_cnt, exp_q[0].kind);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   initial begin
      bus.i_Button_State = 1'b0;
      // Reset with input low, then a press two cycles later.
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      hold(1'b0, 2);
      hold(1'b1, 2);
      hold(1'b0, 3);
      // Short press.
      hold(1'b1, 3);
      hold(1'b0, 3);
      // Long press with repeats.
      hold(1'b1, 20);
      hold(1'b0, 3);
      // Release exactly on the long threshold edge, then on the first repeat edge.
      hold(1'b1, 8);
      hold(1'b0, 3);
      hold(1'b1, 12);
      hold(1'b0, 3);
      // Reset with input high.
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      hold(1'b1, 30);
      hold(1'b0, 1);
      hold(1'b1, 2);
      hold(1'b0, 3);
      // Reset while held.
      hold(1'b1, 10);
      step(1'b1, 1'b1);
      hold(1'b1, 5);
      hold(1'b0, 2);
      hold(1'b1, 3);
      hold(1'b0, 3);
      // Randomised segments with occasional resets.
      for (int s = 0; s < 60; s++) begin
         if ($urandom_range(0, 15) == 0) begin
            step(1'($urandom_range(0, 1)), 1'b1);
         end else begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = (lvl && $urandom_range(0, 2) == 0) ? int'($urandom_range(6, 24))
                                                     : int'($urandom_range(1, 10));
            hold(lvl, len);
         end
      end
      hold(1'b0, 4);
      mon_en = 1'b0;
      @(negedge i_Clock);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL pending_events got=%0d want=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
